gactx_tb_arbiter: RTL and testbench

- Shares one GACT-X traceback unit (BT logic) between NUM_REQ systolic-array requesters.
- Round-robin arbitration; drives the select for the requester-side parameter/BRAM muxes.
- Pulses the BT start, waits for the BT done, captures the traceback results and returns them to the granted requester over a valid/ready response channel.
- Sits between the array-control FSMs and the single BT-logic instance in the GACT-X tile.

---
 rtl/gactx_tb_pkg.sv | 27 ++
 rtl/gactx_rr_pick.sv | 37 +++
 rtl/gactx_tb_arbiter.sv | 177 +++++++++++++++++
 tb/tb_gactx_tb_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gactx_tb_pkg.sv
// Shared types and defaults for the GACT-X traceback arbiter and its helpers.
package gactx_tb_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_SETUP = S_SETUP,
        ST_START = S_START,
        ST_RUN   = S_RUN,
        ST_RESP  = S_RESP
    } tb_state_t;

    localparam int ADDR_WIDTH_DFLT    = 20;
    localparam int LOG_NUM_PE_DFLT    = 6;
    localparam int REF_LEN_WIDTH_DFLT = 12;

    // Width of the traceback step count carried in the response.
    function automatic int steps_width(input int addr_w, input int log_pe);
        return addr_w + log_pe;
    endfunction

endpackage

// File: rtl/gactx_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping at N-1.
module gactx_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    logic [W:0]   sum;
    logic [W-1:0] cand;

    // Wrap is an explicit subtract so non-power-of-two N never yields an index >= N.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int off = 0; off < N; off++) begin
            sum = {1'b0, ptr} + (W+1)'(off);
            if (sum >= (W+1)'(N)) begin
                sum = sum - (W+1)'(N);
            end
            cand = sum[W-1:0];
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/gactx_tb_arbiter.sv
// Round-robin arbiter sharing one GACT-X traceback unit between NUM_REQ arrays.
// Optional watchdog abort compiled in with GACTX_TB_TIMEOUT_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no service; evaluate req and register grant/sel
// SETUP    | one cycle for requester muxes / BRAM reads to settle
// START    | bt_start high for this single cycle
// RUN      | waiting for bt_done (or watchdog abort)
// RESP     | response held on resp_* until resp_ready
module gactx_tb_arbiter
    import gactx_tb_pkg::*;
#(
    parameter int NUM_REQ           = 4,
    parameter int LOG_NUM_REQ       = 2,
    parameter int ADDR_WIDTH        = ADDR_WIDTH_DFLT,
    parameter int LOG_NUM_PE        = LOG_NUM_PE_DFLT,
    parameter int REF_LEN_WIDTH     = REF_LEN_WIDTH_DFLT,
    parameter int TB_TIMEOUT_CYCLES = 2**20
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req,
    output logic [NUM_REQ-1:0]               grant,
    output logic [LOG_NUM_REQ-1:0]           sel,
    output logic                             bt_start,
    output logic                             bt_rst,
    input  logic                             bt_done,
    input  logic [ADDR_WIDTH+LOG_NUM_PE-1:0] bt_num_tb_steps,
    input  logic [REF_LEN_WIDTH-1:0]         bt_H_offset,
    input  logic [REF_LEN_WIDTH-1:0]         bt_V_offset,
    output logic                             resp_valid,
    input  logic                             resp_ready,
    output logic [LOG_NUM_REQ-1:0]           resp_id,
    output logic [ADDR_WIDTH+LOG_NUM_PE-1:0] resp_num_tb_steps,
    output logic [REF_LEN_WIDTH-1:0]         resp_H_offset,
    output logic [REF_LEN_WIDTH-1:0]         resp_V_offset,
    output logic                             resp_timeout,
    output logic                             busy
);

    localparam int STEPS_W = steps_width(ADDR_WIDTH, LOG_NUM_PE);

    if (NUM_REQ < 2 || NUM_REQ > 16 || LOG_NUM_REQ != $clog2(NUM_REQ) ||
        TB_TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("gactx_tb_arbiter: inconsistent parameters");
    end

    tb_state_t              state;
    logic [LOG_NUM_REQ-1:0] rr_ptr;
    logic [LOG_NUM_REQ-1:0] next_ptr;
    logic [NUM_REQ-1:0]     pick_grant;
    logic [LOG_NUM_REQ-1:0] pick_idx;
    logic                   pick_any;

    gactx_rr_pick #(
        .N (NUM_REQ),
        .W (LOG_NUM_REQ)
    ) u_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign next_ptr = (sel == LOG_NUM_REQ'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    assign busy     = (state != ST_IDLE);

`ifdef GACTX_TB_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TB_TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] wdog;
    logic              abort_pend;
    logic              bt_rst_q;
    logic              timeout_q;

    assign bt_rst       = bt_rst_q;
    assign resp_timeout = timeout_q;
`else
    assign bt_rst       = 1'b0;
    assign resp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            rr_ptr            <= '0;
            grant             <= '0;
            sel               <= '0;
            bt_start          <= 1'b0;
            resp_valid        <= 1'b0;
            resp_id           <= '0;
            resp_num_tb_steps <= '0;
            resp_H_offset     <= '0;
            resp_V_offset     <= '0;
`ifdef GACTX_TB_TIMEOUT_EN
            wdog              <= '0;
            abort_pend        <= 1'b0;
            bt_rst_q          <= 1'b0;
            timeout_q         <= 1'b0;
`endif
        end else begin
            bt_start <= 1'b0;
`ifdef GACTX_TB_TIMEOUT_EN
            bt_rst_q <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant <= pick_grant;
                        sel   <= pick_idx;
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    bt_start <= 1'b1;
                    state    <= ST_START;
                end
                ST_START: begin
`ifdef GACTX_TB_TIMEOUT_EN
                    wdog       <= WDOG_W'(TB_TIMEOUT_CYCLES - 1);
                    abort_pend <= 1'b0;
`endif
                    state <= ST_RUN;
                end
                ST_RUN: begin
`ifdef GACTX_TB_TIMEOUT_EN
                    // Once the BT unit has been reset, a late bt_done is meaningless.
                    if (abort_pend) begin
                        abort_pend        <= 1'b0;
                        resp_num_tb_steps <= '0;
                        resp_H_offset     <= '0;
                        resp_V_offset     <= '0;
                        resp_id           <= sel;
                        timeout_q         <= 1'b1;
                        resp_valid        <= 1'b1;
                        state             <= ST_RESP;
                    end else if (bt_done) begin
                        resp_num_tb_steps <= bt_num_tb_steps;
                        resp_H_offset     <= bt_H_offset;
                        resp_V_offset     <= bt_V_offset;
                        resp_id           <= sel;
                        timeout_q         <= 1'b0;
                        resp_valid        <= 1'b1;
                        state             <= ST_RESP;
                    end else if (wdog == '0) begin
                        bt_rst_q   <= 1'b1;
                        abort_pend <= 1'b1;
                    end else begin
                        wdog <= wdog - 1'b1;
                    end
`else
                    if (bt_done) begin
                        resp_num_tb_steps <= bt_num_tb_steps;
                        resp_H_offset     <= bt_H_offset;
                        resp_V_offset     <= bt_V_offset;
                        resp_id           <= sel;
                        resp_valid        <= 1'b1;
                        state             <= ST_RESP;
                    end
`endif
                end
                ST_RESP: begin
                    if (resp_valid && resp_ready) begin
                        resp_valid <= 1'b0;
                        grant      <= '0;
                        rr_ptr     <= next_ptr;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gactx_tb_arbiter.sv
// Directed self-checking bench for gactx_tb_arbiter (NUM_REQ = 4).
module tb_gactx_tb_arbiter;

    localparam int NR  = 4;
    localparam int LNR = 2;
    localparam int SW  = 26;
    localparam int RLW = 12;
`ifdef GACTX_TB_TIMEOUT_EN
    localparam int TO       = 16;
    localparam int RUN_WAIT = 12;
`else
    localparam int TO       = 2**20;
    localparam int RUN_WAIT = 50;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req;
    logic [NR-1:0]  grant;
    logic [LNR-1:0] sel;
    logic           bt_start;
    logic           bt_rst;
    logic           bt_done;
    logic [SW-1:0]  bt_num_tb_steps;
    logic [RLW-1:0] bt_H_offset;
    logic [RLW-1:0] bt_V_offset;
    logic           resp_valid;
    logic           resp_ready;
    logic [LNR-1:0] resp_id;
    logic [SW-1:0]  resp_num_tb_steps;
    logic [RLW-1:0] resp_H_offset;
    logic [RLW-1:0] resp_V_offset;
    logic           resp_timeout;
    logic           busy;

    int checks = 0;
    int errors = 0;

    gactx_tb_arbiter #(
        .NUM_REQ           (NR),
        .LOG_NUM_REQ       (LNR),
        .ADDR_WIDTH        (20),
        .LOG_NUM_PE        (6),
        .REF_LEN_WIDTH     (RLW),
        .TB_TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req               (req),
        .grant             (grant),
        .sel               (sel),
        .bt_start          (bt_start),
        .bt_rst            (bt_rst),
        .bt_done           (bt_done),
        .bt_num_tb_steps   (bt_num_tb_steps),
        .bt_H_offset       (bt_H_offset),
        .bt_V_offset       (bt_V_offset),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_id           (resp_id),
        .resp_num_tb_steps (resp_num_tb_steps),
        .resp_H_offset     (resp_H_offset),
        .resp_V_offset     (resp_V_offset),
        .resp_timeout      (resp_timeout),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; bt_done = 1'b0; resp_ready = 1'b0;
        bt_num_tb_steps = 26'h3ABCDEF; bt_H_offset = 12'hABC; bt_V_offset = 12'h123;
        tick(); tick();
        checks++; if ({grant, sel, bt_start, bt_rst, resp_valid, resp_timeout, busy} !== 11'b0) begin
            errors++; $display("FAIL rst_ctrl: got grant=%b sel=%0d start=%b btrst=%b rv=%b to=%b busy=%b want all 0",
                                grant, sel, bt_start, bt_rst, resp_valid, resp_timeout, busy); end
        checks++; if ({resp_id, resp_num_tb_steps, resp_H_offset, resp_V_offset} !== 52'b0) begin
            errors++; $display("FAIL rst_fields: got id=%0d steps=%0d H=%0d V=%0d want 0", resp_id, resp_num_tb_steps, resp_H_offset, resp_V_offset); end
        rst = 1'b0;
        tick(); tick();
        checks++; if (grant !== 4'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL idle_no_req: got grant=%b busy=%b want 0000/0", grant, busy); end
        bt_done = 1'b1; tick(); bt_done = 1'b0; tick();
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_in_idle: got rv=%b busy=%b want 0/0", resp_valid, busy); end
    endtask

    task automatic test_single();
        int bad;
        req = 4'b0100;
        tick();
        checks++; if (grant !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1 || bt_start !== 1'b0) begin
            errors++; $display("FAIL single_grant: got grant=%b sel=%0d busy=%b start=%b want 0100/2/1/0", grant, sel, busy, bt_start); end
        bt_done = 1'b1; tick(); bt_done = 1'b0;
        checks++; if (bt_start !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL single_start_lat: got start=%b rv=%b want 1/0", bt_start, resp_valid); end
        req = '0;
        tick();
        checks++; if (bt_start !== 1'b0) begin
            errors++; $display("FAIL single_start_pulse: got start=%b want 0", bt_start); end
        bad = 0;
        for (int i = 0; i < RUN_WAIT - 1; i++) begin
            tick();
            if (bt_start !== 1'b0 || resp_valid !== 1'b0 || bt_rst !== 1'b0 || grant !== 4'b0100) bad++;
        end
        checks++; if (bad != 0) begin
            errors++; $display("FAIL single_run_quiet: got %0d bad cycles want 0", bad); end
        bt_done = 1'b1; bt_num_tb_steps = 26'd37; bt_H_offset = 12'd20; bt_V_offset = 12'd18;
        tick();
        bt_done = 1'b0; bt_num_tb_steps = 26'd999; bt_H_offset = 12'd77; bt_V_offset = 12'd66;
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_timeout !== 1'b0) begin
            errors++; $display("FAIL single_resp: got rv=%b id=%0d to=%b want 1/2/0", resp_valid, resp_id, resp_timeout); end
        checks++; if (resp_num_tb_steps !== 26'd37 || resp_H_offset !== 12'd20 || resp_V_offset !== 12'd18) begin
            errors++; $display("FAIL single_fields: got %0d/%0d/%0d want 37/20/18", resp_num_tb_steps, resp_H_offset, resp_V_offset); end
        resp_ready = 1'b1; tick(); resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0 || grant !== 4'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_release: got rv=%b grant=%b busy=%b want 0/0000/0", resp_valid, grant, busy); end
    endtask

    // Pointer now sits at 3; only bits 0 and 1 request, so the search must wrap to 0.
    task automatic test_ptr_wrap();
        req = 4'b0011;
        tick();
        checks++; if (grant !== 4'b0001 || sel !== 2'd0) begin
            errors++; $display("FAIL wrap_grant: got grant=%b sel=%0d want 0001/0", grant, sel); end
        req = '0;
        tick(); tick();
        bt_done = 1'b1; bt_num_tb_steps = 26'd3; tick(); bt_done = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0) begin
            errors++; $display("FAIL wrap_resp: got rv=%b id=%0d want 1/0", resp_valid, resp_id); end
        resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    endtask

    task automatic test_all_active();
        int n;
        int starts;
        logic [1:0] exp_id;
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111; resp_ready = 1'b1;
        for (int svc = 0; svc < 8; svc++) begin
            exp_id = 2'(svc % 4);
            n = 0;
            while (grant === 4'b0 && n < 4) begin tick(); n++; end
            checks++; if (grant !== (4'b0001 << exp_id) || sel !== exp_id) begin
                errors++; $display("FAIL rot_grant svc%0d: got grant=%b sel=%0d want id %0d", svc, grant, sel, exp_id); end
            starts = 0;
            for (int c = 0; c < 4; c++) begin tick(); starts += int'(bt_start); end
            bt_done = 1'b1; bt_num_tb_steps = 26'(svc + 100); tick(); bt_done = 1'b0;
            checks++; if (resp_valid !== 1'b1 || resp_id !== exp_id || resp_num_tb_steps !== 26'(svc + 100)) begin
                errors++; $display("FAIL rot_resp svc%0d: got rv=%b id=%0d steps=%0d want 1/%0d/%0d", svc, resp_valid, resp_id, resp_num_tb_steps, exp_id, svc + 100); end
            tick();
            checks++; if (starts != 1 || grant !== 4'b0) begin
                errors++; $display("FAIL rot_starts svc%0d: got starts=%0d grant=%b want 1/0000", svc, starts, grant); end
        end
        req = '0; resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int bad;
        req = 4'b0010;
        tick();
        checks++; if (grant !== 4'b0010) begin
            errors++; $display("FAIL bp_grant: got %b want 0010", grant); end
        tick(); tick();
        bt_done = 1'b1; bt_num_tb_steps = 26'd100; bt_H_offset = 12'd7; bt_V_offset = 12'd9;
        tick(); bt_done = 1'b0;
        req = 4'b1111;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            bt_done = (i == 4); bt_num_tb_steps = 26'(500 + i); bt_H_offset = 12'(i); bt_V_offset = 12'(i);
            tick();
            if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_num_tb_steps !== 26'd100 ||
                resp_H_offset !== 12'd7 || resp_V_offset !== 12'd9 || grant !== 4'b0010 ||
                bt_start !== 1'b0 || busy !== 1'b1) bad++;
        end
        bt_done = 1'b0;
        checks++; if (bad != 0) begin
            errors++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
        resp_ready = 1'b1; tick(); resp_ready = 1'b0; req = '0;
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || grant !== 4'b0) begin
            errors++; $display("FAIL bp_release: got busy=%b rv=%b grant=%b want 0/0/0000", busy, resp_valid, grant); end
        tick();
        checks++; if (grant !== 4'b0) begin
            errors++; $display("FAIL bp_idle: got grant=%b want 0000", grant); end
    endtask

    task automatic test_req_drop();
        req = 4'b0010;
        tick();
        checks++; if (grant !== 4'b0010 || sel !== 2'd1) begin
            errors++; $display("FAIL drop_grant: got grant=%b sel=%0d want 0010/1", grant, sel); end
        tick(); tick();
        req = '0;
        tick(); tick();
        bt_done = 1'b1; bt_num_tb_steps = 26'd5; bt_H_offset = 12'd6; bt_V_offset = 12'd7;
        tick(); bt_done = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_num_tb_steps !== 26'd5 ||
                      resp_H_offset !== 12'd6 || resp_V_offset !== 12'd7) begin
            errors++; $display("FAIL drop_resp: got rv=%b id=%0d %0d/%0d/%0d want 1/1 5/6/7", resp_valid, resp_id, resp_num_tb_steps, resp_H_offset, resp_V_offset); end
        resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    endtask

    task automatic test_rst_in_run();
        req = 4'b0100;
        tick(); tick(); tick(); tick();
        req = '0;
        rst = 1'b1; tick(); rst = 1'b0;
        checks++; if (grant !== 4'b0 || resp_valid !== 1'b0 || busy !== 1'b0 || bt_start !== 1'b0) begin
            errors++; $display("FAIL rstrun_state: got grant=%b rv=%b busy=%b start=%b want 0", grant, resp_valid, busy, bt_start); end
        req = 4'b0001;
        tick();
        checks++; if (grant !== 4'b0001 || sel !== 2'd0) begin
            errors++; $display("FAIL rstrun_grant: got grant=%b sel=%0d want 0001/0", grant, sel); end
        req = '0;
        tick();
        checks++; if (bt_start !== 1'b1) begin
            errors++; $display("FAIL rstrun_start: got %b want 1", bt_start); end
        tick();
        bt_done = 1'b1; bt_num_tb_steps = 26'd11; bt_H_offset = 12'd12; bt_V_offset = 12'd13;
        tick(); bt_done = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_num_tb_steps !== 26'd11 ||
                      resp_H_offset !== 12'd12 || resp_V_offset !== 12'd13) begin
            errors++; $display("FAIL rstrun_resp: got rv=%b id=%0d %0d/%0d/%0d want 1/0 11/12/13", resp_valid, resp_id, resp_num_tb_steps, resp_H_offset, resp_V_offset); end
        resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    endtask

`ifdef GACTX_TB_TIMEOUT_EN
    task automatic test_timeout();
        int bad;
        bt_num_tb_steps = 26'd4321; bt_H_offset = 12'd55; bt_V_offset = 12'd66;
        req = 4'b1000;
        tick(); req = '0;
        tick(); tick();
        bad = 0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (bt_rst !== 1'b0 || resp_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin
            errors++; $display("FAIL to_early: got %0d bad cycles want 0", bad); end
        tick();
        checks++; if (bt_rst !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL to_btrst: got btrst=%b rv=%b want 1/0", bt_rst, resp_valid); end
        tick();
        checks++; if (bt_rst !== 1'b0 || resp_valid !== 1'b1 || resp_timeout !== 1'b1 || resp_id !== 2'd3 ||
                      resp_num_tb_steps !== 26'd0 || resp_H_offset !== 12'd0 || resp_V_offset !== 12'd0) begin
            errors++; $display("FAIL to_resp: got btrst=%b rv=%b to=%b id=%0d %0d/%0d/%0d want 0/1/1/3 0/0/0",
                                bt_rst, resp_valid, resp_timeout, resp_id, resp_num_tb_steps, resp_H_offset, resp_V_offset); end
        resp_ready = 1'b1; tick(); resp_ready = 1'b0;
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL to_release: got busy=%b rv=%b want 0/0", busy, resp_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_ptr_wrap();
        test_all_active();
        test_backpressure();
        test_req_drop();
        test_rst_in_run();
`ifdef GACTX_TB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
